auth_resp_tx: RTL and testbench

Downstream stage of the authentication responder. Captures a completed response (4-byte header, payload, USB control fields, timeout), serializes it MSB-first as a byte stream toward the USB control-transfer transport, and returns a one-cycle acknowledge that the responder consumes on its `Ack_in`. An optional stall watchdog aborts a transfer the transport never drains.

---
 rtl/auth_resp_tx_pkg.sv | 22 ++
 rtl/auth_resp_tx_if.sv | 24 ++
 rtl/auth_tx_stall_watchdog.sv | 28 ++
 rtl/auth_resp_tx.sv | 179 +++++++++++++++++
 tb/tb_auth_resp_tx.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/auth_resp_tx_pkg.sv
// Shared constants, one-hot transmit states and length clamp for the auth response transmitter.
// Sizes mirror the responder's message format: 4-byte header inside a 512-bit message.
package auth_resp_tx_pkg;

  localparam int SIZE_OF_HEADER_IN_BYTES = 4;
  localparam int MSG_LEN                 = 512;
  localparam int SIZE_OF_STATES_TX       = 5;
  localparam int AUTH_TX_BYTE_W          = 8;

  typedef enum logic [SIZE_OF_STATES_TX-1:0] {
    IDLE    = 5'b00001,
    HEADER  = 5'b00010,
    PAYLOAD = 5'b00100,
    DONE    = 5'b01000,
    ABORT   = 5'b10000
  } tx_state_e;

  function automatic logic [15:0] clamp_len(input logic [15:0] req, input logic [15:0] cap);
    return (req > cap) ? cap : req;
  endfunction

endpackage

// File: rtl/auth_resp_tx_if.sv
// Byte stream toward the USB control-transfer transport plus the latched USB setup fields.
// master = transmitter (drives data/valid/last and fields), slave = transport (drives ready).
interface auth_resp_tx_if;
  import auth_resp_tx_pkg::*;

  logic [AUTH_TX_BYTE_W-1:0] tx_data;
  logic                      tx_valid;
  logic                      tx_ready;
  logic                      tx_last;
  logic [7:0]                usb_bmRequestType;
  logic [7:0]                usb_bRequest;
  logic [15:0]               usb_wLength;

  modport master (
    output tx_data, tx_valid, tx_last, usb_bmRequestType, usb_bRequest, usb_wLength,
    input  tx_ready
  );

  modport slave (
    input  tx_data, tx_valid, tx_last, usb_bmRequestType, usb_bRequest, usb_wLength,
    output tx_ready
  );

endinterface

// File: rtl/auth_tx_stall_watchdog.sv
// Saturating stall counter; expired when count equals a nonzero limit. Present only with AUTH_RESP_TX_TIMEOUT_EN.
// Latency: expired is combinational from the registered count; clear has priority over counting.
`ifdef AUTH_RESP_TX_TIMEOUT_EN
module auth_tx_stall_watchdog (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        count_en,
  input  logic [31:0] limit,
  output logic        expired
);

  logic [31:0] stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 32'd0;
    end else if (clear) begin
      stall_cnt <= 32'd0;
    end else if (count_en && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign expired = (limit != 32'd0) && (stall_cnt == limit);

endmodule
`endif

// File: rtl/auth_resp_tx.sv
// Serializes a captured auth response (header, then payload, MSB-first); first byte the cycle after a msg_req rise,
// byte held stable while tx_ready is low; stall abort only when AUTH_RESP_TX_TIMEOUT_EN is defined.
module auth_resp_tx
  import auth_resp_tx_pkg::*;
#(
  parameter int HDR_BYTES = SIZE_OF_HEADER_IN_BYTES,
  parameter int PAY_BYTES = (MSG_LEN / 8) - HDR_BYTES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   msg_req,
  input  logic [8*HDR_BYTES-1:0] header_in,
  input  logic [8*PAY_BYTES-1:0] payload_in,
  input  logic [7:0]             bmRequestType_in,
  input  logic [7:0]             bRequest_in,
  input  logic [15:0]            wLength_in,
  input  logic [31:0]            timeout_in,
  auth_resp_tx_if.master         tx,
  output logic                   ack_out,
  output logic                   tx_timeout,
  output logic                   busy
);

  localparam logic [15:0] HDR_LAST = 16'(HDR_BYTES - 1);
  localparam logic [15:0] PAY_CAP  = 16'(PAY_BYTES);
  localparam logic [31:0] HDR_TOP  = 32'(8 * (HDR_BYTES - 1));
  localparam logic [31:0] PAY_TOP  = 32'(8 * (PAY_BYTES - 1));

  tx_state_e state_q, state_d;
  logic                   req_q;
  logic                   start;
  logic                   acc;
  logic                   expired;
  logic [8*HDR_BYTES-1:0] hdr_q;
  logic [8*PAY_BYTES-1:0] pay_q;
  logic [7:0]             bm_q;
  logic [7:0]             br_q;
  logic [15:0]            len_q;
  logic [15:0]            idx_q;
  logic [15:0]            idx_d;
  logic [31:0]            hdr_sh;
  logic [31:0]            pay_sh;
  logic                   is_hdr_last;
  logic                   is_pay_last;

  assign start       = msg_req & ~req_q & (state_q == IDLE);
  assign acc         = tx.tx_valid & tx.tx_ready;
  assign is_hdr_last = (idx_q == HDR_LAST);
  assign is_pay_last = (idx_q == (len_q - 16'd1));

  // req_q resets high so a request still asserted when reset releases is treated as stale.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q <= 1'b1;
    end else begin
      req_q <= msg_req;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hdr_q <= '0;
      pay_q <= '0;
      bm_q  <= 8'd0;
      br_q  <= 8'd0;
      len_q <= 16'd0;
    end else if (start) begin
      hdr_q <= header_in;
      pay_q <= payload_in;
      bm_q  <= bmRequestType_in;
      br_q  <= bRequest_in;
      len_q <= clamp_len(wLength_in, PAY_CAP);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Acceptance is checked before the watchdog so a byte taken on the expiry cycle still counts.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = HEADER;
          idx_d   = 16'd0;
        end
      end
      HEADER: begin
        if (acc) begin
          if (is_hdr_last) begin
            idx_d   = 16'd0;
            state_d = (len_q == 16'd0) ? DONE : PAYLOAD;
          end else begin
            idx_d = idx_q + 16'd1;
          end
        end else if (expired) begin
          state_d = ABORT;
        end
      end
      PAYLOAD: begin
        if (acc) begin
          if (is_pay_last) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 16'd1;
          end
        end else if (expired) begin
          state_d = ABORT;
        end
      end
      DONE:    state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Out-of-range shift amounts wrap to huge values and yield zero rather than X.
  assign hdr_sh = HDR_TOP - {13'd0, idx_q, 3'd0};
  assign pay_sh = PAY_TOP - {13'd0, idx_q, 3'd0};

  always_comb begin
    tx.tx_valid = 1'b0;
    tx.tx_data  = '0;
    tx.tx_last  = 1'b0;
    if (state_q == HEADER) begin
      tx.tx_valid = 1'b1;
      tx.tx_data  = 8'(hdr_q >> hdr_sh);
      tx.tx_last  = is_hdr_last && (len_q == 16'd0);
    end else if (state_q == PAYLOAD) begin
      tx.tx_valid = 1'b1;
      tx.tx_data  = 8'(pay_q >> pay_sh);
      tx.tx_last  = is_pay_last;
    end
  end

  assign tx.usb_bmRequestType = bm_q;
  assign tx.usb_bRequest      = br_q;
  assign tx.usb_wLength       = len_q;
  assign ack_out              = (state_q == DONE);
  assign busy                 = (state_q != IDLE);

`ifdef AUTH_RESP_TX_TIMEOUT_EN
  logic [31:0] timeout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_q <= 32'd0;
    end else if (start) begin
      timeout_q <= timeout_in;
    end
  end

  auth_tx_stall_watchdog u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear    (acc | start),
    .count_en (tx.tx_valid & ~tx.tx_ready),
    .limit    (timeout_q),
    .expired  (expired)
  );

  assign tx_timeout = (state_q == ABORT);
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_in;
  assign expired        = 1'b0;
  assign tx_timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_auth_resp_tx.sv
// Directed bench for auth_resp_tx: expected bytes queued at start, compared on each acceptance.
module tb_auth_resp_tx;
  import auth_resp_tx_pkg::*;

  localparam int HDR = SIZE_OF_HEADER_IN_BYTES;
  localparam int PAY = MSG_LEN / 8 - HDR;

  logic               clk = 1'b0;
  logic               reset;
  logic               msg_req;
  logic [8*HDR-1:0]   header_in;
  logic [8*PAY-1:0]   payload_in;
  logic [7:0]         bmRequestType_in;
  logic [7:0]         bRequest_in;
  logic [15:0]        wLength_in;
  logic [31:0]        timeout_in;
  logic               ack_out;
  logic               tx_timeout;
  logic               busy;

  auth_resp_tx_if tx_if ();

  auth_resp_tx #(.HDR_BYTES(HDR), .PAY_BYTES(PAY)) dut (
    .clk              (clk),
    .reset            (reset),
    .msg_req          (msg_req),
    .header_in        (header_in),
    .payload_in       (payload_in),
    .bmRequestType_in (bmRequestType_in),
    .bRequest_in      (bRequest_in),
    .wLength_in       (wLength_in),
    .timeout_in       (timeout_in),
    .tx               (tx_if),
    .ack_out          (ack_out),
    .tx_timeout       (tx_timeout),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int         n_checks;
  int         n_pass;
  logic [8:0] exp_q[$];
  int         cyc;
  int         accepted;
  int         ack_cyc;
  int         to_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pay_pat(input int k, input logic [7:0] seed);
    return 8'(k * 13) ^ seed;
  endfunction

  // Drives a new request (caller sits at a negedge) and queues the expected byte stream.
  task automatic start_xfer(input logic [31:0] hdr, input int wlen, input logic [31:0] tmo,
                            input logic [7:0] seed);
    int n;
    logic [7:0] b;
    n = (wlen > PAY) ? PAY : wlen;
    header_in        = hdr;
    wLength_in       = 16'(wlen);
    timeout_in       = tmo;
    bmRequestType_in = seed ^ 8'hA1;
    bRequest_in      = seed ^ 8'h5C;
    for (int k = 0; k < PAY; k++) payload_in[8*(PAY-1-k) +: 8] = pay_pat(k, seed);
    exp_q.delete();
    for (int i = 0; i < HDR; i++) begin
      b = 8'(hdr >> (8 * (HDR - 1 - i)));
      exp_q.push_back({(n == 0) && (i == HDR - 1), b});
    end
    for (int k = 0; k < n; k++) exp_q.push_back({k == n - 1, pay_pat(k, seed)});
    msg_req = 1'b1;
  endtask

  // mode 0: ready held high; 1: ready low on cycles 6,7; 2: ready low after three acceptances.
  task automatic run_stream(input int mode, input int budget, input bit expect_end);
    logic       stalled;
    logic       rdy;
    logic [8:0] prev;
    logic [8:0] obs;
    logic [8:0] e;
    cyc = 0; ack_cyc = 0; to_cyc = 0; accepted = 0; stalled = 1'b0; prev = '0;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      obs = {tx_if.tx_last, tx_if.tx_data};
      if (ack_out) begin
        ack_cyc = cyc;
        break;
      end
      if (tx_timeout) begin
        to_cyc = cyc;
        check("abort_valid_low", tx_if.tx_valid, 1'b0);
        break;
      end
      if (stalled) begin
        check("stall_valid_hold", tx_if.tx_valid, 1'b1);
        check("stall_data_hold", obs, prev);
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = !(cyc == 6 || cyc == 7);
        default: rdy = (accepted < 3);
      endcase
      tx_if.tx_ready = rdy;
      if (tx_if.tx_valid && rdy) begin
        check("queue_has_byte", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("byte_last_data", obs, e);
        end
        accepted++;
      end
      stalled = tx_if.tx_valid && !rdy;
      prev    = obs;
    end
    if (expect_end) check("end_seen", (ack_cyc + to_cyc) > 0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_pass = 0;
    reset = 1'b1; msg_req = 1'b0; header_in = '0; payload_in = '0;
    bmRequestType_in = 8'd0; bRequest_in = 8'd0; wLength_in = 16'd0; timeout_in = 32'd0;
    tx_if.tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tx_valid", tx_if.tx_valid, 1'b0);
    check("rst_tx_data", tx_if.tx_data, 8'd0);
    check("rst_tx_last", tx_if.tx_last, 1'b0);
    check("rst_ack", ack_out, 1'b0);
    check("rst_timeout", tx_timeout, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_usb_wlen", tx_if.usb_wLength, 16'd0);
    check("rst_usb_bm", tx_if.usb_bmRequestType, 8'd0);
    reset = 1'b0;
    @(negedge clk);

    // 32-byte payload, continuous ready
    start_xfer(32'h0101_0000, 32, 32'd0, 8'h11);
    run_stream(0, 100, 1'b1);
    check("t1_ack_cycle", ack_cyc, HDR + 32 + 1);
    check("t1_bytes", accepted, 36);
    check("t1_queue_empty", exp_q.size(), 0);
    check("t1_usb_wlen", tx_if.usb_wLength, 16'd32);
    check("t1_usb_bm", tx_if.usb_bmRequestType, 8'h11 ^ 8'hA1);
    check("t1_usb_breq", tx_if.usb_bRequest, 8'h11 ^ 8'h5C);
    @(negedge clk);
    check("t1_ack_one_cycle", ack_out, 1'b0);
    check("t1_idle_after", busy, 1'b0);
    repeat (3) @(negedge clk);
    check("t1_no_retrigger", busy, 1'b0);
    msg_req = 1'b0;
    @(negedge clk);

    // header only
    start_xfer(32'hDEAD_BEEF, 0, 32'd0, 8'h22);
    run_stream(0, 50, 1'b1);
    check("t2_ack_cycle", ack_cyc, HDR + 1);
    check("t2_bytes", accepted, HDR);
    check("t2_usb_wlen", tx_if.usb_wLength, 16'd0);
    msg_req = 1'b0;
    @(negedge clk);

    // oversize length is clamped
    start_xfer(32'hA5A5_5A5A, PAY + 10, 32'd0, 8'h33);
    run_stream(0, 200, 1'b1);
    check("t3_ack_cycle", ack_cyc, HDR + PAY + 1);
    check("t3_bytes", accepted, HDR + PAY);
    check("t3_usb_wlen_clamped", tx_if.usb_wLength, 16'(PAY));
    msg_req = 1'b0;
    @(negedge clk);

    // ready 1-0-0-1 during payload
    start_xfer(32'h1234_5678, 16, 32'd0, 8'h44);
    run_stream(1, 100, 1'b1);
    check("t4_ack_cycle", ack_cyc, HDR + 16 + 1 + 2);
    check("t4_bytes", accepted, HDR + 16);
    check("t4_queue_empty", exp_q.size(), 0);
    msg_req = 1'b0;
    @(negedge clk);

`ifdef AUTH_RESP_TX_TIMEOUT_EN
    // stall after byte 2 with limit 5: abort, then a fresh edge restarts at header byte 0
    start_xfer(32'hCAFE_F00D, 20, 32'd5, 8'h55);
    run_stream(2, 100, 1'b1);
    check("t5_timeout_cycle", to_cyc, 10);
    check("t5_no_ack", ack_cyc, 0);
    check("t5_bytes_before_stall", accepted, 3);
    @(negedge clk);
    check("t5_timeout_one_cycle", tx_timeout, 1'b0);
    check("t5_busy_low", busy, 1'b0);
    check("t5_ack_low", ack_out, 1'b0);
    msg_req = 1'b0;
    @(negedge clk);
    start_xfer(32'h0F0E_0D0C, 0, 32'd5, 8'h66);
    run_stream(0, 50, 1'b1);
    check("t5_restart_ack_cycle", ack_cyc, HDR + 1);
    check("t5_restart_bytes", accepted, HDR);
`else
    // without the watchdog a stalled transfer waits, then completes once drained
    start_xfer(32'hCAFE_F00D, 20, 32'd5, 8'h55);
    run_stream(2, 20, 1'b0);
    check("t5_no_timeout", to_cyc, 0);
    check("t5_no_ack_while_stalled", ack_cyc, 0);
    check("t5_bytes_before_stall", accepted, 3);
    check("t5_still_busy", busy, 1'b1);
    run_stream(0, 100, 1'b1);
    check("t5_drain_ack_cycle", ack_cyc, 20 + HDR - 3 + 1);
    check("t5_drain_bytes", accepted, 20 + HDR - 3);
    check("t5_queue_empty", exp_q.size(), 0);
`endif
    msg_req = 1'b0;
    @(negedge clk);

    // reset during payload, request held high across reset
    start_xfer(32'h0101_0000, 32, 32'd0, 8'h77);
    run_stream(0, 8, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_valid", tx_if.tx_valid, 1'b0);
    check("t6_rst_data", tx_if.tx_data, 8'd0);
    check("t6_rst_last", tx_if.tx_last, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_ack", ack_out, 1'b0);
    check("t6_rst_timeout", tx_timeout, 1'b0);
    check("t6_rst_usb_wlen", tx_if.usb_wLength, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_held_req_idle", busy, 1'b0);
    end
    msg_req = 1'b0;
    @(negedge clk);
    start_xfer(32'h0101_0000, 32, 32'd0, 8'h88);
    run_stream(0, 100, 1'b1);
    check("t6_new_xfer_ack_cycle", ack_cyc, HDR + 32 + 1);
    check("t6_new_xfer_bytes", accepted, HDR + 32);
    msg_req = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
